ysyx_23060201_ctrl: RTL and testbench

//  Multi-cycle sequencer for the single-issue NPC core: owns the PC and steps IFU fetch -> EXU execute -> LSU access -> GPR writeback.

---
 rtl/ysyx_23060201_ctrl_if.sv | 23 ++
 rtl/ysyx_23060201_ctrl.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060201_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_ctrl_if.sv
// Memory-side handshake bundle for the NPC sequencer: instruction fetch port and data port.
// The master side is the sequencer; the slave side is the memory system.
interface ysyx_23060201_ctrl_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        mem_we;

    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid, mem_we,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid, mem_we,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
    );
endinterface

// File: rtl/ysyx_23060201_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: fetch -> execute -> memory -> writeback,
// with sticky halt on ebreak or on a memory-response timeout.
module ysyx_23060201_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_23060201_ctrl_if.master bus,
    output logic [31:0]          inst,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_ebreak,
    input  logic [31:0]          exu_dnpc,
    output logic                 gpr_we,
    output logic [31:0]          pc,
    output logic                 commit,
    output logic [CNT_W-1:0]     retired,
    output logic                 halt,
    output logic                 err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, HALT
    } state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     inst_reg;
    logic [CNT_W-1:0] retired_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic            is_store_reg;
    logic            ifu_req_valid_reg;
    logic            lsu_req_valid_reg;
    logic            mem_we_reg;
    logic            gpr_we_reg;
    logic            commit_reg;
    logic            halt_reg;
    logic            err_reg;
    logic            stalled;

    // Any cycle spent in a request/response state without the awaited handshake.
    always_comb begin
        stalled = 1'b0;
        case (state_reg)
            F_REQ:   stalled = ~bus.ifu_req_ready;
            F_WAIT:  stalled = ~bus.ifu_rsp_valid;
            M_REQ:   stalled = ~bus.lsu_req_ready;
            M_WAIT:  stalled = ~bus.lsu_rsp_valid;
            default: stalled = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            pc_reg            <= RESET_PC;
            inst_reg          <= '0;
            retired_reg       <= '0;
            wait_cnt_reg      <= '0;
            is_store_reg      <= 1'b0;
            ifu_req_valid_reg <= 1'b0;
            lsu_req_valid_reg <= 1'b0;
            mem_we_reg        <= 1'b0;
            gpr_we_reg        <= 1'b0;
            commit_reg        <= 1'b0;
            halt_reg          <= 1'b0;
            err_reg           <= 1'b0;
        end else if (stalled) begin
            if (wait_cnt_reg == WAIT_LAST) begin
                state_reg         <= HALT;
                halt_reg          <= 1'b1;
                err_reg           <= 1'b1;
                ifu_req_valid_reg <= 1'b0;
                lsu_req_valid_reg <= 1'b0;
                mem_we_reg        <= 1'b0;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end else begin
            // Every forward step restarts the wait budget for the next state.
            wait_cnt_reg <= '0;
            case (state_reg)
                IDLE: begin
                    state_reg         <= F_REQ;
                    ifu_req_valid_reg <= 1'b1;
                end
                F_REQ: begin
                    state_reg         <= F_WAIT;
                    ifu_req_valid_reg <= 1'b0;
                end
                F_WAIT: begin
                    state_reg <= EXEC;
                    inst_reg  <= bus.ifu_rsp_data;
                end
                EXEC: begin
                    if (dec_ebreak) begin
                        state_reg <= HALT;
                        halt_reg  <= 1'b1;
                    end else if (dec_load || dec_store) begin
                        state_reg         <= M_REQ;
                        lsu_req_valid_reg <= 1'b1;
                        mem_we_reg        <= dec_store;
                        is_store_reg      <= dec_store;
                    end else begin
                        state_reg    <= WB;
                        is_store_reg <= 1'b0;
                        commit_reg   <= 1'b1;
                        gpr_we_reg   <= 1'b1;
                    end
                end
                M_REQ: begin
                    state_reg         <= M_WAIT;
                    lsu_req_valid_reg <= 1'b0;
                    mem_we_reg        <= 1'b0;
                end
                M_WAIT: begin
                    state_reg  <= WB;
                    commit_reg <= 1'b1;
                    gpr_we_reg <= ~is_store_reg;
                end
                WB: begin
                    state_reg         <= F_REQ;
                    pc_reg            <= exu_dnpc;
                    retired_reg       <= retired_reg + CNT_W'(1);
                    commit_reg        <= 1'b0;
                    gpr_we_reg        <= 1'b0;
                    ifu_req_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ifu_req_valid = ifu_req_valid_reg;
    assign bus.ifu_addr      = pc_reg;
    assign bus.lsu_req_valid = lsu_req_valid_reg;
    assign bus.mem_we        = mem_we_reg;
    assign inst              = inst_reg;
    assign gpr_we            = gpr_we_reg;
    assign pc                = pc_reg;
    assign commit            = commit_reg;
    assign retired           = retired_reg;
    assign halt              = halt_reg;
    assign err               = err_reg;
endmodule

// File: tb/tb_ysyx_23060201_ctrl.sv
// Randomized scoreboard bench for the NPC sequencer: a responder drives memory/decoder stimulus
// and queues expectations; a negedge monitor pops and compares fetches, memory requests, commits, halts.
module tb_ysyx_23060201_ctrl;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060201_ctrl_if bus ();
    logic [31:0]      inst, exu_dnpc, pc;
    logic             dec_load, dec_store, dec_ebreak;
    logic             gpr_we, commit, halt, err;
    logic [CNT_W-1:0] retired;

    ysyx_23060201_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst),
        .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak),
        .exu_dnpc(exu_dnpc), .gpr_we(gpr_we), .pc(pc), .commit(commit),
        .retired(retired), .halt(halt), .err(err)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             gpr_we;
        logic [CNT_W-1:0] ret;
        int               lat;
    } commit_t;
    typedef struct {
        logic             err;
        logic [31:0]      pc;
        logic [CNT_W-1:0] ret;
    } halt_t;

    logic [31:0] fetch_q[$];
    bit          lsu_q[$];
    commit_t     commit_q[$];
    halt_t       halt_q[$];

    int checks = 0;
    int failures = 0;
    logic [31:0]      pc_m;
    logic [CNT_W-1:0] ret_m;

    localparam int M_NORMAL = 0, M_EBREAK = 1, M_FTO = 2, M_LTO = 3, M_RSTMID = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_request required=request_within_budget t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ifu(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.ifu_req_valid) begin ok = 1'b1; return; end
            tick();
        end
        bound_fail("ifu_req_wait");
    endtask

    task automatic wait_lsu(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.lsu_req_valid) begin ok = 1'b1; return; end
            tick();
        end
        bound_fail("lsu_req_wait");
    endtask

    task automatic clear_inputs();
        bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0; bus.ifu_rsp_data = '0;
        bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0;
        dec_load = 0; dec_store = 0; dec_ebreak = 0; exu_dnpc = '0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_flags", {24'd0, halt, err, commit, gpr_we, bus.ifu_req_valid,
                          bus.lsu_req_valid, bus.mem_we, 1'b0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pc_m  = RESET_PC;
        ret_m = '0;
        chk("idle_no_req", 32'(bus.ifu_req_valid), 32'd0);
    endtask

    // kind: 0 alu, 1 load, 2 store
    task automatic run_instr(input int mode, input int kind, input int rdy, input int rsp,
                             input int lrdy, input int lrsp);
        logic [31:0] cur, dnpc, word;
        bit ok, mem;
        cur  = pc_m;
        dnpc = $urandom;
        word = $urandom;
        mem  = (kind != 0);
        fetch_q.push_back(cur);
        case (mode)
            M_NORMAL: begin
                commit_q.push_back('{cur, word, kind != 2, ret_m,
                                     4 + rdy + rsp + (mem ? 2 + lrdy + lrsp : 0)});
                if (mem) lsu_q.push_back(kind == 2);
                pc_m  = dnpc;
                ret_m = ret_m + 1'b1;
            end
            M_EBREAK: halt_q.push_back('{1'b0, cur, ret_m});
            M_FTO, M_LTO: halt_q.push_back('{1'b1, cur, ret_m});
            default: ;
        endcase

        wait_ifu(ok);
        if (!ok) return;
        for (int i = 0; i < rdy; i++) begin
            chk("ifu_valid_stall", 32'(bus.ifu_req_valid), 32'd1);
            chk("ifu_addr_stall", bus.ifu_addr, cur);
            bus.ifu_rsp_valid = 1'($urandom_range(0, 1));
            bus.ifu_rsp_data  = $urandom;
            tick();
        end
        bus.ifu_rsp_valid = 0;
        bus.ifu_req_ready = 1;
        tick();
        bus.ifu_req_ready = 0;

        if (mode == M_FTO) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                tick();
                chk("fto_halt", 32'(halt), 32'(k == TIMEOUT));
            end
            chk("fto_err", 32'(err), 32'd1);
            repeat (4) tick();
            return;
        end
        if (mode == M_RSTMID) begin
            repeat (2) tick();
            return;
        end

        repeat (rsp) tick();
        bus.ifu_rsp_valid = 1;
        bus.ifu_rsp_data  = word;
        exu_dnpc   = dnpc;
        dec_ebreak = (mode == M_EBREAK);
        dec_load   = (mode == M_EBREAK) ? 1'($urandom_range(0, 1)) : (kind == 1 || mode == M_LTO);
        dec_store  = (mode == M_EBREAK) ? 1'b0 : (kind == 2);
        tick();
        bus.ifu_rsp_valid = 0;

        if (mode == M_EBREAK) begin
            repeat (6) tick();
            chk("ebreak_halt", 32'(halt), 32'd1);
            chk("ebreak_err", 32'(err), 32'd0);
            return;
        end
        if (!(mem || mode == M_LTO)) return;

        wait_lsu(ok);
        if (!ok) return;
        if (mode == M_LTO) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                tick();
                chk("lto_halt", 32'(halt), 32'(k == TIMEOUT));
            end
            repeat (4) tick();
            return;
        end
        for (int i = 0; i < lrdy; i++) begin
            chk("mem_we_stall", 32'(bus.mem_we), 32'(kind == 2));
            bus.lsu_rsp_valid = 1'($urandom_range(0, 1));
            tick();
        end
        bus.lsu_rsp_valid = 0;
        bus.lsu_req_ready = 1;
        tick();
        bus.lsu_req_ready = 0;
        repeat (lrsp) tick();
        bus.lsu_rsp_valid = 1;
        tick();
        bus.lsu_rsp_valid = 0;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_instr(M_NORMAL, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake, commit or halt.
    int cyc, last_commit;
    bit in_rst, halt_seen;
    logic [31:0] halt_pc;
    initial begin
        in_rst = 0; halt_seen = 0; cyc = 0; last_commit = 1; halt_pc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (!in_rst) begin
                    in_rst = 1;
                    chk("leftover_expect", 32'(fetch_q.size() + lsu_q.size() + commit_q.size()
                                               + halt_q.size()), 32'd0);
                end
                fetch_q.delete(); lsu_q.delete(); commit_q.delete(); halt_q.delete();
                cyc = 0; last_commit = 1; halt_seen = 0;
            end else begin
                in_rst = 0;
                cyc++;
                if (bus.ifu_req_valid && bus.ifu_req_ready) begin
                    if (fetch_q.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
                    else chk("fetch_addr", bus.ifu_addr, fetch_q.pop_front());
                end
                if (bus.lsu_req_valid && bus.lsu_req_ready) begin
                    if (lsu_q.size() == 0) chk("lsu_unexpected", 32'd1, 32'd0);
                    else chk("lsu_mem_we", 32'(bus.mem_we), 32'(lsu_q.pop_front()));
                end
                if (!bus.lsu_req_valid) chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
                if (commit) begin
                    if (commit_q.size() == 0) chk("commit_unexpected", 32'd1, 32'd0);
                    else begin
                        commit_t c;
                        c = commit_q.pop_front();
                        chk("commit_pc", pc, c.pc);
                        chk("commit_inst", inst, c.inst);
                        chk("commit_gpr_we", 32'(gpr_we), 32'(c.gpr_we));
                        chk("commit_retired", 32'(retired), 32'(c.ret));
                        chk("commit_latency", 32'(cyc - last_commit), 32'(c.lat));
                    end
                    last_commit = cyc;
                end else begin
                    chk("gpr_we_idle", 32'(gpr_we), 32'd0);
                end
                if (halt && !halt_seen) begin
                    halt_seen = 1;
                    if (halt_q.size() == 0) chk("halt_unexpected", 32'd1, 32'd0);
                    else begin
                        halt_t h;
                        h = halt_q.pop_front();
                        halt_pc = h.pc;
                        chk("halt_err", 32'(err), 32'(h.err));
                        chk("halt_retired", 32'(retired), 32'(h.ret));
                    end
                end
                if (halt) begin
                    chk("halt_quiet", {29'd0, bus.ifu_req_valid, bus.lsu_req_valid, commit}, 32'd0);
                    chk("halt_pc", pc, halt_pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        pc_m = RESET_PC;
        ret_m = '0;
        do_reset();
        // Directed: zero-wait ALU, fetch stall, waited load, store, then random and ebreak.
        run_instr(M_NORMAL, 0, 0, 0, 0, 0);
        run_instr(M_NORMAL, 0, 3, 0, 0, 0);
        run_instr(M_NORMAL, 1, 0, 0, 0, 2);
        run_instr(M_NORMAL, 2, 0, 0, 1, 0);
        run_random(20);
        run_instr(M_EBREAK, 0, 1, 1, 0, 0);

        do_reset();
        run_random(25);
        run_instr(M_FTO, 0, 0, 0, 0, 0);

        do_reset();
        run_random(8);
        run_instr(M_LTO, 1, 1, 0, 0, 0);

        do_reset();
        run_random(5);
        run_instr(M_RSTMID, 0, 0, 0, 0, 0);
        do_reset();
        run_random(4);
        run_instr(M_EBREAK, 0, 0, 0, 0, 0);

        do_reset();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
